// File: rtl/r2l_exp_pkg.sv
// Shared state encoding and next-state helper for the right-to-left exponentiation engine.
package r2l_exp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_SQR  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    SQR  = ST_SQR,
    FIN  = ST_FIN
  } state_t;

  // Next phase for a remaining exponent: done when exhausted, multiply on a set LSB, else square.
  function automatic state_t nxt_state(input logic e_zero, input logic e_lsb);
    if (e_zero) begin
      return FIN;
    end else if (e_lsb) begin
      return MUL;
    end else begin
      return SQR;
    end
  endfunction

endpackage

// File: rtl/r2l_exp_mul.sv
// Unsigned W x W multiplier returning the wrapped low half and an upper-half-nonzero flag.
module r2l_exp_mul #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] lo_c_o,
  output logic         hi_nz_c_o
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] prod;

  // Full-width product so the overflow flag sees every discarded bit.
  always_comb begin
    prod = PW'(a_i) * PW'(b_i);
  end

  assign lo_c_o    = prod[W-1:0];
  assign hi_nz_c_o = |prod[PW-1:W];

endmodule

// File: rtl/r2l_exp.sv
// LSB-first binary exponentiation C = A^B mod 2^(2k) with one shared multiplier.
// Optional overflow reporting is compiled in with `define R2L_OVF_EN.
module r2l_exp
  import r2l_exp_pkg::*;
#(
  parameter int unsigned k = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [k-1:0]   A,
  input  logic [k-1:0]   B,
  input  logic           start,
  output logic [2*k-1:0] C,
  output logic           Done
`ifdef R2L_OVF_EN
  ,
  output logic           Ovf
`endif
);

  localparam int unsigned W = 2 * k;

  state_t         state_q, state_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   x_q, x_d;
  logic [k-1:0]   e_q, e_d;
  logic           done_q, done_d;
  logic [k-1:0]   e_shr;
  logic [W-1:0]   mul_a, mul_lo;
  logic           mul_hi_nz;
`ifdef R2L_OVF_EN
  logic           ovf_q, ovf_d;
  logic           xo_q, xo_d;
`else
  logic           hi_nz_unused;
  assign hi_nz_unused = mul_hi_nz;
`endif

  // Shared multiplier: R*X while multiplying, X*X while squaring.
  r2l_exp_mul #(.W(W)) u_mul (
    .a_i       (mul_a),
    .b_i       (x_q),
    .lo_c_o    (mul_lo),
    .hi_nz_c_o (mul_hi_nz)
  );

  // Operand mux, next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    x_d     = x_q;
    e_d     = e_q;
    done_d  = done_q;
`ifdef R2L_OVF_EN
    ovf_d   = ovf_q;
    xo_d    = xo_q;
`endif
    e_shr   = e_q >> 1;
    mul_a   = (state_q == SQR) ? x_q : r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = W'(1);
          x_d     = W'(A);
          e_d     = B;
          done_d  = 1'b0;
          state_d = nxt_state(B == '0, B[0]);
`ifdef R2L_OVF_EN
          ovf_d   = 1'b0;
          xo_d    = 1'b0;
`endif
        end
      end
      MUL: begin
        r_d     = mul_lo;
        // No higher exponent bits left: the trailing square would be wasted.
        state_d = (e_shr == '0) ? FIN : SQR;
`ifdef R2L_OVF_EN
        ovf_d   = ovf_q | xo_q | mul_hi_nz;
`endif
      end
      SQR: begin
        x_d     = mul_lo;
        e_d     = e_shr;
        state_d = nxt_state(e_shr == '0, e_shr[0]);
`ifdef R2L_OVF_EN
        xo_d    = xo_q | mul_hi_nz;
`endif
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      x_q     <= '0;
      e_q     <= '0;
      done_q  <= 1'b0;
`ifdef R2L_OVF_EN
      ovf_q   <= 1'b0;
      xo_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      e_q     <= e_d;
      done_q  <= done_d;
`ifdef R2L_OVF_EN
      ovf_q   <= ovf_d;
      xo_q    <= xo_d;
`endif
    end
  end

  assign C    = r_q;
  assign Done = done_q;
`ifdef R2L_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_r2l_exp.sv
// Self-checking bench for r2l_exp (k=16): directed vectors, busy/reset/back-to-back cases, random operands.
module tb_r2l_exp;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        start;
  logic [31:0] C;
  logic        Done;
`ifdef R2L_OVF_EN
  logic        Ovf;
`endif

  int errors = 0;
  int checks = 0;

  r2l_exp #(.k(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .start (start),
    .C     (C),
    .Done  (Done)
`ifdef R2L_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain repeated multiplication, with an unwrapped copy to detect overflow.
  task automatic ref_pow(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] res, output logic ovf, output int lat);
    logic [63:0] p;
    logic [63:0] sat;
    int          n;
    p   = 64'd1;
    sat = 64'd1;
    ovf = 1'b0;
    for (int i = 0; i < int'(b); i++) begin
      p = (p * 64'(a)) & 64'hFFFF_FFFF;
      if (!ovf) begin
        sat = sat * 64'(a);
        if (sat >= 64'h1_0000_0000) ovf = 1'b1;
      end
    end
    res = p[31:0];
    n   = (b == 16'd0) ? 0 : $clog2(int'(b) + 1);
    lat = $countones(b) + n;
    if (lat < 1) lat = 1;
  endtask

  // Waits up to budget edges for Done; cyc = -1 when it never rises.
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (Done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Starts one operation from IDLE and checks result, latency and overflow against the model.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag, output int lat);
    logic [31:0] eres;
    logic        eovf;
    int          elat;
    ref_pow(a, b, eres, eovf, elat);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_clr"}, 64'(Done), 64'd0);
    wait_done(64, lat);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_C"}, 64'(C), 64'(eres));
`ifdef R2L_OVF_EN
    check({tag, "_ovf"}, 64'(Ovf), 64'(eovf));
`else
    if (eovf) begin end
`endif
  endtask

  initial begin
    int lat;
    int cyc;
    logic [15:0] ra, rb;
    A = '0;
    B = '0;
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_C", 64'(C), 64'd0);
    check("rst_Done", 64'(Done), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors with literal expectations.
    run_op(16'd3, 16'd5, "p3_5", lat);
    check("lit3_5_C", 64'(C), 64'hF3);
    check("lit3_5_lat", 64'(lat), 64'd5);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 64'(Done), 64'd1);
    run_op(16'd0, 16'd0, "p0_0", lat);
    check("lit0_0_C", 64'(C), 64'd1);
    check("lit0_0_lat", 64'(lat), 64'd1);
    run_op(16'd0, 16'd7, "p0_7", lat);
    check("lit0_7_C", 64'(C), 64'd0);
    run_op(16'hFFFF, 16'd2, "pffff_2", lat);
    check("litffff_C", 64'(C), 64'hFFFE_0001);
    check("litffff_lat", 64'(lat), 64'd3);
    run_op(16'd2, 16'd31, "p2_31", lat);
    check("lit2_31_C", 64'(C), 64'h8000_0000);
    run_op(16'd2, 16'd32, "p2_32", lat);
    check("lit2_32_C", 64'(C), 64'd0);
    check("lit2_32_lat", 64'(lat), 64'd7);
    run_op(16'd1, 16'hFFFF, "p1_max", lat);
    check("lit1_max_C", 64'(C), 64'd1);

    // Start while busy must not disturb the operation in flight.
    @(negedge clk);
    A = 16'd3;
    B = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    A = 16'd5;
    B = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(64, cyc);
    check("busy_lat", 64'(cyc + 1), 64'd5);
    check("busy_C", 64'(C), 64'hF3);

    // Asynchronous reset mid-operation clears everything at once.
    @(negedge clk);
    A = 16'd3;
    B = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_C", 64'(C), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_C", 64'(C), 64'd0);
    check("async_rst_Done", 64'(Done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(16'd5, 16'd2, "post_rst", lat);
    check("post_rst_C", 64'(C), 64'd25);

    // Start held high: restart is accepted on the edge after FIN.
    @(negedge clk);
    A = 16'd3;
    B = 16'd5;
    start = 1'b1;
    @(posedge clk);
    wait_done(64, cyc);
    check("b2b_lat1", 64'(cyc), 64'd5);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_restart_clr", 64'(Done), 64'd0);
    wait_done(64, cyc);
    check("b2b_lat2", 64'(cyc), 64'd5);
    check("b2b_C", 64'(C), 64'hF3);

    // Random operands against the model.
    for (int t = 0; t < 24; t++) begin
      ra = 16'($urandom);
      rb = (t < 12) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      run_op(ra, rb, $sformatf("rnd%0d", t), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
